lsu_ctrl: RTL and testbench

// - Load/store unit between the MEM pipeline stage and the word-addressed data RAM.
// - Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses.
// - Does byte/halfword stores as read-modify-write and sign/zero-extends loads.
// - Owns the RAM's shared tri-state data bus (mem_data).

---
 rtl/lsu_ctrl_pkg.sv | 44 ++++
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_ctrl_align.sv | 46 ++++
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request decode helpers used by lsu_ctrl and its alignment sub-module.
package lsu_ctrl_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_RD   = 2'd1,
        LSU_WR   = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        if (store) begin
            ok = (funct3 == LSU_SB) || (funct3 == LSU_SH) || (funct3 == LSU_SW);
        end else begin
            ok = (funct3 == LSU_LB) || (funct3 == LSU_LH) || (funct3 == LSU_LW) ||
                 (funct3 == LSU_LBU) || (funct3 == LSU_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] encodes the access width for loads and stores alike.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = offset[0];
            2'b10:   bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response channel between the MEM stage (master) and the LSU (slave).
interface lsu_ctrl_if #(
    parameter int DATA_W = 32
);
    // A request transfers on a posedge where req_valid && req_ready; the master
    // holds req_* stable while req_valid is high. resp_valid is a single-cycle
    // pulse with no backpressure, and req_ready stays low until it has passed.
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// merges store data into the old word for read-modify-write stores.
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = word[{offset[1], 4'b0000} +: 16];
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            LSU_LB:  load_data = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
            LSU_LH:  load_data = {{(DATA_W-16){lane_half[15]}}, lane_half};
            LSU_LW:  load_data = word;
            LSU_LBU: load_data = {{(DATA_W-8){1'b0}}, lane_byte};
            LSU_LHU: load_data = {{(DATA_W-16){1'b0}}, lane_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            LSU_SB:  store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            LSU_SH:  store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            LSU_SW:  store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: request latch, error decode, RD/WR/DONE sequencing and the
// tri-state driver for the data RAM's shared bus.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    lsu_ctrl_if.slave         lsu,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output lsu_state_e        fsm_state
);

    lsu_state_e        state_q, state_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic              range_err;
    logic              drive;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign lsu.req_ready = (state_q == LSU_IDLE) && !rst;
    assign accept        = lsu.req_valid && lsu.req_ready;
    assign fsm_state     = state_q;

    // Word index compared at full width so DEPTH never gets truncated.
    assign range_err = {2'b00, lsu.req_addr[DATA_W-1:2]} >= DATA_W'(DEPTH);
    assign req_err   = !funct3_legal(lsu.req_store, lsu.req_funct3) ||
                       misaligned(lsu.req_funct3, lsu.req_addr[1:0]) ||
                       range_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LSU_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q  <= lsu.req_store;
                funct3_q <= lsu.req_funct3;
                addr_q   <= lsu.req_addr;
                wdata_q  <= lsu.req_wdata;
                err_q    <= req_err;
            end
            if (state_q == LSU_RD) begin
                word_q <= mem_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = LSU_DONE;
                    end else if (lsu.req_store && (lsu.req_funct3 == LSU_SW)) begin
                        state_d = LSU_WR;
                    end else begin
                        state_d = LSU_RD;
                    end
                end
            end
            LSU_RD:   state_d = store_q ? LSU_WR : LSU_DONE;
            LSU_WR:   state_d = LSU_DONE;
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        mem_valid      = 1'b0;
        mem_we         = 1'b1;
        mem_addr       = '0;
        drive          = 1'b0;
        lsu.resp_valid = 1'b0;
        lsu.resp_rdata = '0;
        lsu.resp_err   = 1'b0;
        case (state_q)
            LSU_RD: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[DATA_W-1:2], 2'b00};
            end
            LSU_WR: begin
                mem_valid = 1'b1;
                mem_we    = 1'b0;
                mem_addr  = {addr_q[DATA_W-1:2], 2'b00};
                drive     = 1'b1;
            end
            LSU_DONE: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_err   = err_q;
                if (!store_q && !err_q) begin
                    lsu.resp_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

    // Only the WR state drives the bus; the RAM owns it at all other times.
    assign mem_data = drive ? store_word : {DATA_W{1'bz}};

    lsu_ctrl_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .word      (word_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural data RAM on the shared bus, a vector table of
// requests with a response scoreboard, and hand sequences for reset and timing.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 64;
    localparam logic [31:0] BUS_IDLE = 32'hA5C3_5A3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    lsu_state_e  fsm_state;

    lsu_ctrl_if #(.DATA_W(DATA_W)) lsu ();

    lsu_ctrl #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lsu      (lsu),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data RAM model ----------------
    logic [31:0] ram [0:DEPTH-1];
    logic [5:0]  ram_idx;
    assign ram_idx  = mem_addr[7:2];
    assign mem_data = mem_we ? (mem_valid ? ram[ram_idx] : BUS_IDLE) : 32'hz;

    always @(negedge clk) begin
        if (mem_valid && !mem_we) ram[ram_idx] <= mem_data;
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    string       cur_name = "reset";
    logic [32:0] exp_q[$];
    int          last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (mem_we) check({cur_name, "_bus"}, mem_data, mem_valid ? ram[ram_idx] : BUS_IDLE);
        if (!mem_valid) check({cur_name, "_addr_idle"}, mem_addr, 32'h0);
        else            check({cur_name, "_addr_align"}, {30'b0, mem_addr[1:0]}, 32'h0);
        if (lsu.resp_valid) begin
            check({cur_name, "_resp_expected"}, {31'b0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({cur_name, "_rdata"}, lsu.resp_rdata, e[31:0]);
                check({cur_name, "_err"}, {31'b0, lsu.resp_err}, {31'b0, e[32]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int   n;
        int   waited;
        logic got;
        cur_name = name;
        @(negedge clk);
        waited = 0;
        while (!lsu.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_ready"}, {31'b0, lsu.req_ready}, 32'h1);
        if (!lsu.req_ready) return;
        lsu.req_valid  = 1'b1;
        lsu.req_store  = st;
        lsu.req_funct3 = f3;
        lsu.req_addr   = addr;
        lsu.req_wdata  = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        last_accept = cyc;
        #1;
        lsu.req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            check({name, "_busy"}, {31'b0, lsu.req_ready}, 32'h0);
            if (exp_err) check({name, "_no_mem"}, {31'b0, mem_valid}, 32'h0);
            if (lsu.resp_valid) got = 1'b1;
        end
        check({name, "_latency"}, got ? n : 99, exp_lat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err, input int lat);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          w;
        int          lane;
        logic [31:0] d;
        logic [31:0] b;
        logic [31:0] h;

        lsu.req_valid  = 1'b0;
        lsu.req_store  = 1'b0;
        lsu.req_funct3 = 3'b000;
        lsu.req_addr   = 32'h0;
        lsu.req_wdata  = 32'h0;

        //         st    f3       addr      wdata          rdata          err lat
        add(1'b1, LSU_SW,  32'h10,  32'hDEADBEEF, 32'h0,         1'b0, 2);
        add(1'b0, LSU_LW,  32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 2);
        add(1'b1, LSU_SB,  32'h12,  32'hAAAAAA55, 32'h0,         1'b0, 3);
        add(1'b0, LSU_LB,  32'h12,  32'h0,        32'h00000055,  1'b0, 2);
        add(1'b0, LSU_LB,  32'h13,  32'h0,        32'hFFFFFFDE,  1'b0, 2);
        add(1'b0, LSU_LBU, 32'h13,  32'h0,        32'h000000DE,  1'b0, 2);
        add(1'b0, LSU_LH,  32'h12,  32'h0,        32'hFFFFDE55,  1'b0, 2);
        add(1'b0, LSU_LHU, 32'h12,  32'h0,        32'h0000DE55,  1'b0, 2);
        add(1'b0, LSU_LW,  32'h11,  32'h0,        32'h0,         1'b1, 1);
        add(1'b1, LSU_SH,  32'h13,  32'h1111,     32'h0,         1'b1, 1);
        add(1'b0, 3'b011,  32'h10,  32'h0,        32'h0,         1'b1, 1);
        add(1'b0, LSU_LW,  32'h100, 32'h0,        32'h0,         1'b1, 1);
        add(1'b1, 3'b100,  32'h10,  32'h77777777, 32'h0,         1'b1, 1);
        add(1'b0, LSU_LW,  32'h10,  32'h0,        32'hDE55BEEF,  1'b0, 2);
        add(1'b1, LSU_SW,  32'h14,  32'hCAFEF00D, 32'h0,         1'b0, 2);
        add(1'b1, LSU_SH,  32'h16,  32'hABCD1234, 32'h0,         1'b0, 3);
        add(1'b0, LSU_LW,  32'h14,  32'h0,        32'h1234F00D,  1'b0, 2);
        add(1'b0, LSU_LH,  32'h14,  32'h0,        32'hFFFFF00D,  1'b0, 2);
        add(1'b0, LSU_LHU, 32'h16,  32'h0,        32'h00001234,  1'b0, 2);
        add(1'b1, LSU_SB,  32'h10,  32'h00000080, 32'h0,         1'b0, 3);
        add(1'b0, LSU_LB,  32'h10,  32'h0,        32'hFFFFFF80,  1'b0, 2);
        add(1'b1, LSU_SW,  32'hFC,  32'h0BADF00D, 32'h0,         1'b0, 2);
        add(1'b0, LSU_LW,  32'hFC,  32'h0,        32'h0BADF00D,  1'b0, 2);
        add(1'b0, LSU_LH,  32'h11,  32'h0,        32'h0,         1'b1, 1);
        add(1'b0, LSU_LBU, 32'h11,  32'h0,        32'h000000BE,  1'b0, 2);
        add(1'b1, LSU_SB,  32'h100, 32'h12,       32'h0,         1'b1, 1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h1);
        check("rst_resp_valid", {31'b0, lsu.resp_valid}, 32'h0);
        check("rst_resp_rdata", lsu.resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, lsu.resp_err}, 32'h0);
        check("rst_ready_low", {31'b0, lsu.req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", {30'b0, fsm_state}, {30'b0, LSU_IDLE});
        check("rst_ready_high", {31'b0, lsu.req_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req($sformatf("v%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].err, vecs[i].lat);
        end
        check("ram_w4", ram[4], 32'hDE55BE80);
        check("ram_w5", ram[5], 32'h1234F00D);

        // Back-to-back loads: one request per latency+1 cycles
        do_req("b2b_a", 1'b0, LSU_LW, 32'h14, 32'h0, 32'h1234F00D, 1'b0, 2);
        t0 = last_accept;
        do_req("b2b_b", 1'b0, LSU_LW, 32'h10, 32'h0, 32'hDE55BE80, 1'b0, 2);
        check("b2b_spacing", last_accept - t0, 3);

        // Reset during the RD cycle of an SB aborts it without a response
        do_req("rst_seed", 1'b1, LSU_SW, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
        cur_name = "rst_mid";
        @(negedge clk);
        lsu.req_valid  = 1'b1;
        lsu.req_store  = 1'b1;
        lsu.req_funct3 = LSU_SB;
        lsu.req_addr   = 32'h21;
        lsu.req_wdata  = 32'h99;
        @(posedge clk);
        #1;
        lsu.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_rd", {30'b0, fsm_state}, {30'b0, LSU_RD});
        @(negedge clk);
        check("rst_mid_state", {30'b0, fsm_state}, {30'b0, LSU_IDLE});
        check("rst_mid_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("rst_mid_no_resp", {31'b0, lsu.resp_valid}, 32'h0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_quiet", {31'b0, lsu.resp_valid}, 32'h0);
        end
        check("rst_mid_ram", ram[8], 32'h11223344);
        do_req("rst_after", 1'b0, LSU_LW, 32'h20, 32'h0, 32'h11223344, 1'b0, 2);

        // Random word stores followed by byte/half reads of a random lane
        for (int k = 0; k < 6; k++) begin
            w    = $urandom_range(24, 39);
            d    = $urandom;
            lane = $urandom_range(0, 3);
            b    = (d >> (8 * lane)) & 32'hFF;
            h    = (d >> (16 * (lane / 2))) & 32'hFFFF;
            do_req($sformatf("rnd%0d_sw", k), 1'b1, LSU_SW, w * 4, d, 32'h0, 1'b0, 2);
            do_req($sformatf("rnd%0d_lbu", k), 1'b0, LSU_LBU, w * 4 + lane, 32'h0, b, 1'b0, 2);
            do_req($sformatf("rnd%0d_lb", k), 1'b0, LSU_LB, w * 4 + lane, 32'h0,
                   b[7] ? (b | 32'hFFFFFF00) : b, 1'b0, 2);
            do_req($sformatf("rnd%0d_lh", k), 1'b0, LSU_LH, w * 4 + (lane / 2) * 2, 32'h0,
                   h[15] ? (h | 32'hFFFF0000) : h, 1'b0, 2);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
